// File: rtl/doppler_framer.sv
// Overlapping I/Q framer: buffers the decimated stream and replays FRAME_LEN-sample frames
// advancing by HOP. Optional overflow counter enabled by DOPPLER_FRAMER_OVF_CNT_EN.
module doppler_framer #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned HOP       = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          slow_clk,
  input  logic          reset_n,
  input  logic          din_valid_Fs,
  input  logic [DW-1:0] din_re_Fs,
  input  logic [DW-1:0] din_im_Fs,
  output logic          dout_valid_Fs,
  input  logic          dout_ready_Fs,
  output logic          dout_sop_Fs,
  output logic          dout_eop_Fs,
  output logic [DW-1:0] dout_re_Fs,
  output logic [DW-1:0] dout_im_Fs,
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
  input  logic          ovf_clear_Fs,
  output logic [15:0]   ovf_count_Fs,
`endif
  output logic          overflow_Fs
);

  localparam int unsigned BUF_DEPTH = 2 * FRAME_LEN;
  localparam int unsigned AW        = $clog2(BUF_DEPTH);
  localparam int unsigned CW        = $clog2(FRAME_LEN);
  localparam logic [AW:0]   L_FULL  = BUF_DEPTH[AW:0];
  localparam logic [AW:0]   L_FRAME = FRAME_LEN[AW:0];
  localparam logic [AW:0]   L_HOP   = HOP[AW:0];
  localparam logic [AW-1:0] L_HOP_A = HOP[AW-1:0];
  localparam logic [CW-1:0] L_LAST  = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StWait, StSend, StDrain} state_e;

  logic [2*DW-1:0] r_mem [BUF_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_base, r_rd_addr;
  logic [CW-1:0]   r_rd_cnt;
  logic [AW:0]     r_avail;
  state_e          r_state, w_state_d;
  logic            r_dout_valid, r_dout_sop, r_dout_eop, r_ovf;
  logic [2*DW-1:0] r_dout_data;
  logic            w_full, w_wr_accept, w_drop, w_out_free, w_rd_en, w_frame_done, w_start;

  // Fullness is judged on the registered count; a same-cycle frame_done does not free space.
  assign w_full       = (r_avail == L_FULL);
  assign w_wr_accept  = din_valid_Fs & ~w_full;
  assign w_drop       = din_valid_Fs & w_full;
  assign w_out_free   = ~r_dout_valid | dout_ready_Fs;
  assign w_frame_done = (r_state == StDrain) & r_dout_valid & dout_ready_Fs & r_dout_eop;
  assign w_start      = (r_state == StWait) & (w_state_d == StSend);

  always_comb begin
    w_state_d = r_state;
    w_rd_en   = 1'b0;
    unique case (r_state)
      StWait: begin
        if (r_avail >= L_FRAME) w_state_d = StSend;
      end
      StSend: begin
        if (w_out_free) begin
          w_rd_en = 1'b1;
          if (r_rd_cnt == L_LAST) w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_frame_done) w_state_d = StWait;
      end
      default: w_state_d = StWait;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= {din_re_Fs, din_im_Fs};
  end

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StWait;
      r_wr_ptr     <= '0;
      r_base       <= '0;
      r_rd_addr    <= '0;
      r_rd_cnt     <= '0;
      r_avail      <= '0;
      r_ovf        <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_sop   <= 1'b0;
      r_dout_eop   <= 1'b0;
      r_dout_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ovf   <= w_drop;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_avail <= r_avail + {{AW{1'b0}}, w_wr_accept} - (w_frame_done ? L_HOP : '0);
      if (w_frame_done) r_base <= r_base + L_HOP_A;
      if (w_start) begin
        r_rd_addr <= r_base;
        r_rd_cnt  <= '0;
      end else if (w_rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
      // The RAM read register doubles as the output register.
      if (w_rd_en) begin
        r_dout_valid <= 1'b1;
        r_dout_sop   <= (r_rd_cnt == '0);
        r_dout_eop   <= (r_rd_cnt == L_LAST);
        r_dout_data  <= r_mem[r_rd_addr];
      end else if (dout_ready_Fs) begin
        r_dout_valid <= 1'b0;
        r_dout_sop   <= 1'b0;
        r_dout_eop   <= 1'b0;
      end
    end
  end

  assign dout_valid_Fs = r_dout_valid;
  assign dout_sop_Fs   = r_dout_sop;
  assign dout_eop_Fs   = r_dout_eop;
  assign dout_re_Fs    = r_dout_data[2*DW-1:DW];
  assign dout_im_Fs    = r_dout_data[DW-1:0];
  assign overflow_Fs   = r_ovf;

`ifdef DOPPLER_FRAMER_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clear_Fs) begin
      r_ovf_cnt <= '0;
    end else if (r_ovf && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_count_Fs = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_doppler_framer.sv
// Bench for doppler_framer (FRAME_LEN=8, HOP=4): accepted-sample queue model plus directed checks.
module tb_doppler_framer;

  localparam int unsigned FL = 8;
  localparam int unsigned HP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BD = 2 * FL;

  logic          slow_clk = 1'b0;
  logic          reset_n;
  logic          din_valid_Fs;
  logic [DW-1:0] din_re_Fs, din_im_Fs;
  logic          dout_valid_Fs, dout_ready_Fs, dout_sop_Fs, dout_eop_Fs;
  logic [DW-1:0] dout_re_Fs, dout_im_Fs;
  logic          overflow_Fs;
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
  logic          ovf_clear_Fs;
  logic [15:0]   ovf_count_Fs;
`endif

  always #5 slow_clk = ~slow_clk;

  doppler_framer #(
    .FRAME_LEN(FL),
    .HOP      (HP),
    .DW       (DW)
  ) dut (
    .slow_clk     (slow_clk),
    .reset_n      (reset_n),
    .din_valid_Fs (din_valid_Fs),
    .din_re_Fs    (din_re_Fs),
    .din_im_Fs    (din_im_Fs),
    .dout_valid_Fs(dout_valid_Fs),
    .dout_ready_Fs(dout_ready_Fs),
    .dout_sop_Fs  (dout_sop_Fs),
    .dout_eop_Fs  (dout_eop_Fs),
    .dout_re_Fs   (dout_re_Fs),
    .dout_im_Fs   (dout_im_Fs),
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    .ovf_clear_Fs (ovf_clear_Fs),
    .ovf_count_Fs (ovf_count_Fs),
`endif
    .overflow_Fs  (overflow_Fs)
  );

  // Model: every accepted sample in order; frame n is acc_q[n*HP +: FL].
  logic [2*DW-1:0] acc_q[$];
  int              fr_idx, smp_idx, avail_m;
  bit              ovf_exp, hold_prev, eop_fired, clr_on_ovf;
  logic [2*DW+2:0] snap;
  int              sop_log[$], eop_log[$];
  int              total, bad, cyc, ovf_seen, first_sop_cyc, s7_cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit rp(input int k);
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  task automatic model_reset();
    acc_q.delete();
    sop_log.delete();
    eop_log.delete();
    fr_idx        = 0;
    smp_idx       = 0;
    avail_m       = 0;
    ovf_exp       = 1'b0;
    hold_prev     = 1'b0;
    first_sop_cyc = -1;
  endtask

  // One cycle: check outputs at the negedge, drive inputs, advance the model.
  task automatic step(input bit v, input int val, input bit rdy, input bit v_on_eop);
    bit fire;
    int idx, nv;
    logic [DW-1:0] re, im;
    @(negedge slow_clk);
    cyc++;
    if (hold_prev)
      chk("hold", {dout_valid_Fs, dout_sop_Fs, dout_eop_Fs, dout_re_Fs, dout_im_Fs}, snap);
    chk("overflow", overflow_Fs, ovf_exp);
    if (overflow_Fs) ovf_seen++;
    if (!dout_valid_Fs) chk("flags_idle", {dout_sop_Fs, dout_eop_Fs}, 2'b00);
    if (v_on_eop) v = dout_valid_Fs & dout_eop_Fs & rdy;
    nv = -val;
    re = val[DW-1:0];
    im = nv[DW-1:0];
    din_valid_Fs  = v;
    din_re_Fs     = re;
    din_im_Fs     = im;
    dout_ready_Fs = rdy;
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    ovf_clear_Fs = clr_on_ovf & overflow_Fs;
`endif
    fire      = dout_valid_Fs & rdy;
    eop_fired = 1'b0;
    if (fire) begin
      idx = fr_idx * HP + smp_idx;
      if (idx >= acc_q.size()) begin
        total++;
        bad++;
        $display("FAIL data_exists: got output for sample %0d, expected none", idx);
      end else begin
        chk("data", {dout_re_Fs, dout_im_Fs}, acc_q[idx]);
      end
      chk("sop", dout_sop_Fs, smp_idx == 0);
      chk("eop", dout_eop_Fs, smp_idx == FL - 1);
      if (dout_sop_Fs) begin
        sop_log.push_back(int'(dout_re_Fs));
        if (first_sop_cyc < 0) first_sop_cyc = cyc;
      end
      if (dout_eop_Fs) eop_log.push_back(int'(dout_re_Fs));
    end
    ovf_exp = 1'b0;
    if (v) begin
      if (avail_m == BD) ovf_exp = 1'b1;
      else begin
        acc_q.push_back({re, im});
        avail_m++;
      end
    end
    if (fire) begin
      if (smp_idx == FL - 1) begin
        smp_idx = 0;
        fr_idx++;
        avail_m -= HP;
        eop_fired = 1'b1;
      end else begin
        smp_idx++;
      end
    end
    hold_prev = dout_valid_Fs & ~rdy;
    snap      = {dout_valid_Fs, dout_sop_Fs, dout_eop_Fs, dout_re_Fs, dout_im_Fs};
  endtask

  task automatic do_reset();
    @(negedge slow_clk);
    din_valid_Fs  = 1'b0;
    din_re_Fs     = '0;
    din_im_Fs     = '0;
    dout_ready_Fs = 1'b0;
    reset_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge slow_clk);
    reset_n = 1'b1;
  endtask

  // Frames are expected to start at accepted samples 0, HP, 2*HP, ...
  task automatic check_logs(input string tag, input int n);
    chk({tag, "_nsop"}, sop_log.size(), n);
    chk({tag, "_neop"}, eop_log.size(), n);
    if (sop_log.size() == n && eop_log.size() == n) begin
      for (int j = 0; j < n; j++) begin
        chk({tag, "_sopval"}, sop_log[j], j * HP);
        chk({tag, "_eopval"}, eop_log[j], j * HP + FL - 1);
      end
    end
  endtask

  initial begin
    int k;
    total = 0; bad = 0; cyc = 0; ovf_seen = 0; s7_cyc = 0; clr_on_ovf = 1'b0;
    reset_n = 1'b0; din_valid_Fs = 1'b0; din_re_Fs = '0; din_im_Fs = '0; dout_ready_Fs = 1'b0;
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    ovf_clear_Fs = 1'b0;
`endif
    model_reset();
    #2;
    chk("reset_state", {dout_valid_Fs, dout_sop_Fs, dout_eop_Fs, overflow_Fs,
                        dout_re_Fs, dout_im_Fs}, '0);
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    chk("reset_ovf_count", ovf_count_Fs, 16'h0000);
`endif

    // Scenario 1: one sample every 3 cycles, ready high.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, 1'b1, 1'b0);
      if (i == 7) s7_cyc = cyc;
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    repeat (40) step(1'b0, 0, 1'b1, 1'b0);
    chk("s1_frames", fr_idx, 3);
    chk("s1_latency", first_sop_cyc - s7_cyc, 3);
    check_logs("s1", 3);

    // Scenario 2: same input, ready pattern 1,0,0,1.
    do_reset();
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, rp(k), 1'b0); k++;
      step(1'b0, 0, rp(k), 1'b0); k++;
      step(1'b0, 0, rp(k), 1'b0); k++;
    end
    repeat (80) begin
      step(1'b0, 0, rp(k), 1'b0); k++;
    end
    chk("s2_frames", fr_idx, 3);
    check_logs("s2", 3);

    // Scenario 3: ready low, 20 back-to-back samples; the last 4 overflow.
    do_reset();
    ovf_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b1, i, 1'b0, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    chk("s3_ovf_pulses", ovf_seen, 4);
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    chk("s3_ovf_count", ovf_count_Fs, 16'd4);
`endif
    repeat (50) step(1'b0, 0, 1'b1, 1'b0);
    chk("s3_frames", fr_idx, 3);
    check_logs("s3", 3);

    // Scenario 4: write lands in the frame_done cycle with 15 samples held.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, i, 1'b0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 40 && !eop_fired; n++) step(1'b0, 15, 1'b1, 1'b1);
    if (!eop_fired) begin
      total++;
      bad++;
      $display("FAIL s4_eop_timeout: got no eop within 40 cycles, expected one");
    end
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);
    ovf_seen   = 0;
    clr_on_ovf = 1'b1;
    for (int i = 16; i < 21; i++) step(1'b1, i, 1'b0, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    clr_on_ovf = 1'b0;
    chk("s4_ovf_pulses", ovf_seen, 1);
`ifdef DOPPLER_FRAMER_OVF_CNT_EN
    chk("s4_clear_wins", ovf_count_Fs, 16'd0);
    ovf_clear_Fs = 1'b0;
`endif
    repeat (60) step(1'b0, 0, 1'b1, 1'b0);
    chk("s4_frames", fr_idx, 4);
    check_logs("s4", 4);

    // Scenario 5: asynchronous reset after 3 output samples of a frame.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 100 + i, 1'b1, 1'b0);
    for (int n = 0; n < 40 && smp_idx != 3; n++) step(1'b0, 0, 1'b1, 1'b0);
    chk("s5_midframe", smp_idx, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("s5_async_rst", {dout_valid_Fs, dout_sop_Fs, dout_eop_Fs, overflow_Fs}, 4'b0000);
    din_valid_Fs = 1'b0;
    model_reset();
    @(negedge slow_clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 200 + i, 1'b1, 1'b0);
    repeat (20) step(1'b0, 0, 1'b1, 1'b0);
    chk("s5_frames", fr_idx, 1);
    chk("s5_nsop", sop_log.size(), 1);
    if (sop_log.size() == 1) chk("s5_sop_first", sop_log[0], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
